// File: rtl/dlx_pkg.sv
// rtl/dlx_pkg.sv - DLX shared constants and fetch FSM state type
package dlx_pkg;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h5400_0000;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQZ = 6'h04;
  localparam logic [5:0] OP_BNEZ = 6'h05;
  localparam logic [5:0] OP_JR   = 6'h12;
  localparam logic [5:0] OP_NOP  = 6'h15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register {instr, pc_plus_four, valid}
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h5400_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc_plus_four,
  output logic [31:0] q_instr,
  output logic [31:0] q_pc_plus_four,
  output logic        q_valid
);

  // Reset beats flush, flush beats load; both leave a bubble behind.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      q_instr        <= NOP_INSTR;
      q_pc_plus_four <= 32'd0;
      q_valid        <= 1'b0;
    end else if (load) begin
      q_instr        <= d_instr;
      q_pc_plus_four <= d_pc_plus_four;
      q_valid        <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - DLX IF stage: PC, fetch FSM, hold buffer, IF/ID feed
module instruction_fetch
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        take_branch,
  input  logic [31:0] branch_target,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus_four,
  output logic        if_valid
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  drop_addr;
  logic [31:0]  hold_instr;
  logic [31:0]  hold_pc_plus_four;
  logic [31:0]  pc_plus_four;
  logic         redirect;
  logic         id_load;
  logic [31:0]  id_instr;
  logic [31:0]  id_pc_plus_four;
  logic         unused_target_lsbs;

  assign unused_target_lsbs = ^branch_target[1:0];
  assign pc_plus_four       = pc + 32'd4;
  assign redirect           = take_branch && !stall && (state != IDLE);

  assign imem_req  = (state == REQ) || (state == DROP);
  assign imem_addr = (state == DROP) ? drop_addr : pc;

  always_comb begin
    id_load         = 1'b0;
    id_instr        = imem_rdata;
    id_pc_plus_four = pc_plus_four;
    if (!redirect) begin
      case (state)
        REQ:  id_load = imem_ready && !stall;
        HOLD: begin
          id_load         = !stall;
          id_instr        = hold_instr;
          id_pc_plus_four = hold_pc_plus_four;
        end
        default: id_load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      pc                <= RESET_PC;
      drop_addr         <= RESET_PC;
      hold_instr        <= 32'd0;
      hold_pc_plus_four <= 32'd0;
    end else if (redirect) begin
      pc                <= {branch_target[31:2], 2'b00};
      hold_instr        <= 32'd0;
      hold_pc_plus_four <= 32'd0;
      // An outstanding request must finish at its original address before the target is fetched.
      if ((state == REQ || state == DROP) && !imem_ready) begin
        state <= DROP;
        if (state == REQ) drop_addr <= pc;
      end else begin
        state <= REQ;
      end
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ready) begin
            pc <= pc_plus_four;
            if (stall) begin
              hold_instr        <= imem_rdata;
              hold_pc_plus_four <= pc_plus_four;
              state             <= HOLD;
            end
          end
        end
        HOLD: if (!stall) state <= REQ;
        DROP: if (imem_ready) state <= REQ;
        default: state <= IDLE;
      endcase
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (id_load),
    .flush          (redirect),
    .d_instr        (id_instr),
    .d_pc_plus_four (id_pc_plus_four),
    .q_instr        (if_instr),
    .q_pc_plus_four (if_pc_plus_four),
    .q_valid        (if_valid)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h5400_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        take_branch;
  logic [31:0] branch_target;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus_four;
  logic        if_valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Memory returns its own address as the instruction word.
  assign imem_rdata = imem_addr;

  instruction_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .take_branch     (take_branch),
    .branch_target   (branch_target),
    .if_instr        (if_instr),
    .if_pc_plus_four (if_pc_plus_four),
    .if_valid        (if_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4, input logic v);
    check({tag, "_instr"}, if_instr, ins);
    check({tag, "_pc4"}, if_pc_plus_four, p4);
    check({tag, "_valid"}, {31'd0, if_valid}, {31'd0, v});
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0;
    take_branch = 1'b0; branch_target = 32'd0;
    tick(); tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check_ifid("rst", NOP, 32'd0, 1'b0);

    // 1: zero-wait streaming
    rst_n = 1'b1;
    tick();
    check("t1_req", {31'd0, imem_req}, 32'd1);
    check("t1_addr0", imem_addr, 32'h0);
    tick(); check_ifid("t1_a", 32'h0, 32'h4, 1'b1);
    tick(); check_ifid("t1_b", 32'h4, 32'h8, 1'b1);
    tick(); check_ifid("t1_c", 32'h8, 32'hC, 1'b1);
    tick(); check("t1_addr10", imem_addr, 32'h10);

    // 2: three wait cycles at 0x10
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_addr_hold", imem_addr, 32'h10);
      check_ifid("t2_frozen", 32'hC, 32'h10, 1'b1);
    end
    imem_ready = 1'b1;
    tick(); check_ifid("t2_load", 32'h10, 32'h14, 1'b1);
    tick(); tick(); tick();
    check("t3_addr20", imem_addr, 32'h20);

    // 3: stall while 0x20 returns
    stall = 1'b1;
    tick();
    check_ifid("t3_stall1", 32'h1C, 32'h20, 1'b1);
    check("t3_req1", {31'd0, imem_req}, 32'd0);
    tick();
    check_ifid("t3_stall2", 32'h1C, 32'h20, 1'b1);
    check("t3_req2", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    check_ifid("t3_release", 32'h20, 32'h24, 1'b1);
    check("t3_addr24", imem_addr, 32'h24);

    // 4: zero-wait redirect to unaligned target
    take_branch = 1'b1; branch_target = 32'h103;
    tick();
    check_ifid("t4_flush", NOP, 32'd0, 1'b0);
    check("t4_addr", imem_addr, 32'h100);
    take_branch = 1'b0;
    tick(); check_ifid("t4_target", 32'h100, 32'h104, 1'b1);

    // 5: redirect with a request outstanding at 0x40
    take_branch = 1'b1; branch_target = 32'h40;
    tick();
    take_branch = 1'b0; imem_ready = 1'b0;
    tick(); check("t5_addr40", imem_addr, 32'h40);
    take_branch = 1'b1; branch_target = 32'h200;
    tick();
    check("t5_drop_addr", imem_addr, 32'h40);
    check("t5_drop_req", {31'd0, imem_req}, 32'd1);
    take_branch = 1'b0;
    tick();
    check("t5_drop_wait", imem_addr, 32'h40);
    imem_ready = 1'b1;
    tick();
    check("t5_addr200", imem_addr, 32'h200);
    check_ifid("t5_discard", NOP, 32'd0, 1'b0);
    tick(); check_ifid("t5_target", 32'h200, 32'h204, 1'b1);

    // 6: PC wrap, then reset during a wait
    take_branch = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    check("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    take_branch = 1'b0;
    tick();
    check_ifid("t6_wrap", 32'hFFFF_FFFC, 32'h0, 1'b1);
    check("t6_addr0", imem_addr, 32'h0);
    imem_ready = 1'b0;
    tick(); check("t6_wait", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("t6_rst_req", {31'd0, imem_req}, 32'd0);
    check_ifid("t6_rst", NOP, 32'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    check("t6_restart_req", {31'd0, imem_req}, 32'd1);
    check("t6_restart_addr", imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
